// File: rtl/lzrw1_loopback_checker.sv
// lzrw1_loopback_checker
//   Hardware loopback scoreboard for the LZRW1 compress/decompress core.
//   Every byte entering the compressor is queued in a reference FIFO. Every
//   byte leaving the decompressor pops the head and is compared in order.
//   The checker reports a verdict per block and keeps cumulative status.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   valid, CurByte        compressor input tap (push)
//   out_valid,
//   decompressed_byte     decompressor output tap (pop + compare)
//   finished_cycle        core end-of-block pulse
//   block_done, block_ok  verdict pulse and held verdict for the closed block
//   pass                  sticky: no error of any kind since reset
//   byte_count            bytes compared in the current block (saturating)
//   mismatch_count        cumulative mismatches since reset (saturating)
//   overflow, underflow   sticky FIFO error flags
//   first_err_*           position and bytes of the block's first mismatch
module lzrw1_loopback_checker #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] CurByte,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] decompressed_byte,
  input  logic              finished_cycle,
  output logic              block_done,
  output logic              block_ok,
  output logic              pass,
  output logic [CNT_W-1:0]  byte_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic              overflow,
  output logic              underflow,
  output logic [CNT_W-1:0]  first_err_index,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_next, rd_next;
  logic              err_seen, stopped, block_bad;

  logic              empty, full, pop, push, ovf_evt, udf_evt;
  logic              fresh, seen_base, stop_base, bad_base;
  logic              cmp_en, mism, bad_next, empty_next;
  logic [CNT_W-1:0]  cnt_base;
  logic [DATA_W-1:0] head;

  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Pop sees occupancy before the push; a push into a full FIFO survives
    // only when a pop frees a slot in the same cycle.
    pop      = out_valid && !empty;
    push     = valid && (!full || pop);
    ovf_evt  = valid && full && !pop;
    udf_evt  = out_valid && empty;
    wr_next  = wr_ptr + {{AW{1'b0}}, push};
    rd_next  = rd_ptr + {{AW{1'b0}}, pop};
    head     = mem[rd_ptr[AW-1:0]];

    // A block opens on the first activity seen in IDLE; per-block state is
    // taken as cleared for that cycle so its own compare is counted.
    fresh     = (state == IDLE) && (valid || out_valid || finished_cycle);
    cnt_base  = fresh ? '0 : byte_count;
    seen_base = !fresh && err_seen;
    stop_base = !fresh && stopped;
    // Errors raised while CHECK is reporting belong to the following block.
    bad_base  = (state != CHECK) && block_bad;

    cmp_en     = pop && !stop_base;
    mism       = cmp_en && (head != decompressed_byte);
    bad_next   = bad_base || mism || ovf_evt || udf_evt;
    empty_next = (wr_next == rd_next);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= CurByte;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_seen        <= 1'b0;
      stopped         <= 1'b0;
      block_bad       <= 1'b0;
      block_done      <= 1'b0;
      block_ok        <= 1'b1;
      pass            <= 1'b1;
      byte_count      <= '0;
      mismatch_count  <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      first_err_index <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      block_bad <= bad_next;
      err_seen  <= seen_base || mism;
      stopped   <= stop_base || (STOP_ON_ERR && mism);
      overflow  <= overflow || ovf_evt;
      underflow <= underflow || udf_evt;
      pass      <= pass && !(mism || ovf_evt || udf_evt);

      if (cmp_en)
        byte_count <= (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
      else
        byte_count <= cnt_base;

      if (mism && (mismatch_count != '1))
        mismatch_count <= mismatch_count + CNT_W'(1);

      if (fresh) begin
        first_err_index <= '0;
        first_err_exp   <= '0;
        first_err_act   <= '0;
      end
      if (mism && !seen_base) begin
        first_err_index <= cnt_base;
        first_err_exp   <= head;
        first_err_act   <= decompressed_byte;
      end

      case (state)
        IDLE, RUN: begin
          block_done <= 1'b0;
          if (finished_cycle) begin
            // Verdict includes this cycle's compare and the post-pop occupancy.
            state      <= CHECK;
            block_done <= 1'b1;
            block_ok   <= !bad_next && empty_next;
          end else if (state == IDLE && (valid || out_valid)) begin
            state <= RUN;
          end
        end
        CHECK: begin
          block_done <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          block_done <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzrw1_loopback_checker.sv
// Testbench for lzrw1_loopback_checker. Instance 0: DEPTH=16, STOP_ON_ERR=0.
// Instance 1: DEPTH=4, STOP_ON_ERR=1. Expected block verdicts are queued as
// each block is closed; a monitor pops and compares on every block_done.
module tb_lzrw1_loopback_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        va [2], ov [2], fin [2];
  logic [7:0]  cb [2], db [2];
  logic        bd [2], bok [2], ps [2], ofl [2], ufl [2];
  logic [15:0] bc [2], mc [2], fei [2];
  logic [7:0]  fee [2], fea [2];

  lzrw1_loopback_checker #(.DATA_W(8), .DEPTH(16), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_a (
    .clock(clk), .reset(rst), .valid(va[0]), .CurByte(cb[0]), .out_valid(ov[0]),
    .decompressed_byte(db[0]), .finished_cycle(fin[0]), .block_done(bd[0]),
    .block_ok(bok[0]), .pass(ps[0]), .byte_count(bc[0]), .mismatch_count(mc[0]),
    .overflow(ofl[0]), .underflow(ufl[0]), .first_err_index(fei[0]),
    .first_err_exp(fee[0]), .first_err_act(fea[0]));

  lzrw1_loopback_checker #(.DATA_W(8), .DEPTH(4), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_b (
    .clock(clk), .reset(rst), .valid(va[1]), .CurByte(cb[1]), .out_valid(ov[1]),
    .decompressed_byte(db[1]), .finished_cycle(fin[1]), .block_done(bd[1]),
    .block_ok(bok[1]), .pass(ps[1]), .byte_count(bc[1]), .mismatch_count(mc[1]),
    .overflow(ofl[1]), .underflow(ufl[1]), .first_err_index(fei[1]),
    .first_err_exp(fee[1]), .first_err_act(fea[1]));

  typedef struct {
    logic ok; int bc; int mc; logic ps; logic ofl; logic ufl; int fei; int fee; int fea;
  } exp_t;

  exp_t       q0 [$];
  exp_t       q1 [$];
  logic [7:0] pq [$];
  logic [7:0] eq [$];
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, d, act, exp);
  endtask

  function automatic exp_t mk(input logic ok, input int bcv, input int mcv, input logic psv,
                              input logic of, input logic uf, input int ei, input int ee,
                              input int ea);
    exp_t e;
    e.ok = ok; e.bc = bcv; e.mc = mcv; e.ps = psv; e.ofl = of; e.ufl = uf;
    e.fei = ei; e.fee = ee; e.fea = ea;
    return e;
  endfunction

  task automatic mon(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk("unexpected_block_done", d, 1, 0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk("block_ok",        d, int'(bok[d]), int'(e.ok));
    chk("byte_count",      d, int'(bc[d]),  e.bc);
    chk("mismatch_count",  d, int'(mc[d]),  e.mc);
    chk("pass",            d, int'(ps[d]),  int'(e.ps));
    chk("overflow",        d, int'(ofl[d]), int'(e.ofl));
    chk("underflow",       d, int'(ufl[d]), int'(e.ufl));
    chk("first_err_index", d, int'(fei[d]), e.fei);
    chk("first_err_exp",   d, int'(fee[d]), e.fee);
    chk("first_err_act",   d, int'(fea[d]), e.fea);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rst === 1'b0 && bd[d] === 1'b1) mon(d);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Push pq[t] at cycle t; echo eq[t-lag] at cycle t.
  task automatic stream(input int d, input int lag);
    int n;
    n = (pq.size() > eq.size() + lag) ? pq.size() : eq.size() + lag;
    for (int t = 0; t < n; t++) begin
      va[d] = (t < pq.size());
      cb[d] = (t < pq.size()) ? pq[t] : 8'h00;
      ov[d] = (t >= lag) && (t - lag < eq.size());
      db[d] = ov[d] ? eq[t - lag] : 8'h00;
      cyc();
    end
    va[d] = 1'b0; ov[d] = 1'b0; cb[d] = 8'h00; db[d] = 8'h00;
    pq.delete();
    eq.delete();
  endtask

  task automatic close(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    fin[d] = 1'b1;
    cyc();
    fin[d] = 1'b0;
    @(negedge clk);
    chk("done_latency", d, int'(bd[d]), 1);
    cyc();
    cyc();
  endtask

  task automatic chk_reset(input int d);
    chk("rst_block_done", d, int'(bd[d]),  0);
    chk("rst_block_ok",   d, int'(bok[d]), 1);
    chk("rst_pass",       d, int'(ps[d]),  1);
    chk("rst_byte_count", d, int'(bc[d]),  0);
    chk("rst_mismatch",   d, int'(mc[d]),  0);
    chk("rst_overflow",   d, int'(ofl[d]), 0);
    chk("rst_underflow",  d, int'(ufl[d]), 0);
    chk("rst_fe_index",   d, int'(fei[d]), 0);
    chk("rst_fe_exp",     d, int'(fee[d]), 0);
    chk("rst_fe_act",     d, int'(fea[d]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      va[d] = 1'b0; ov[d] = 1'b0; fin[d] = 1'b0; cb[d] = 8'h00; db[d] = 8'h00;
    end
    cyc(); cyc();
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    cyc();
    rst = 1'b0;
    cyc();

    // Clean loopback, 16 bytes echoed 5 cycles later.
    for (int i = 0; i < 16; i++) begin pq.push_back(8'(i)); eq.push_back(8'(i)); end
    stream(0, 5);
    close(0, mk(1'b1, 16, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0));

    // Fourth byte corrupted to 0xFF.
    for (int i = 0; i < 8; i++) begin
      pq.push_back(8'(i));
      eq.push_back((i == 3) ? 8'hFF : 8'(i));
    end
    stream(0, 2);
    close(0, mk(1'b0, 8, 1, 1'b0, 1'b0, 1'b0, 3, 8'h03, 8'hFF));

    // Leftover: 10 pushed, 9 popped.
    for (int i = 0; i < 10; i++) pq.push_back(8'(8'h20 + i));
    for (int i = 0; i < 9; i++)  eq.push_back(8'(8'h20 + i));
    stream(0, 2);
    close(0, mk(1'b0, 9, 1, 1'b0, 1'b0, 1'b0, 0, 0, 0));

    // Next block drains the leftover 0x29 first.
    eq.push_back(8'h29);
    for (int i = 0; i < 4; i++) begin pq.push_back(8'(8'h30 + i)); eq.push_back(8'(8'h30 + i)); end
    stream(0, 2);
    close(0, mk(1'b1, 5, 1, 1'b0, 1'b0, 1'b0, 0, 0, 0));

    // DEPTH=4: push and pop together while full.
    for (int i = 0; i < 6; i++) begin pq.push_back(8'(8'h60 + i)); eq.push_back(8'(8'h60 + i)); end
    stream(1, 4);
    close(1, mk(1'b1, 6, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0));

    // DEPTH=4: five pushes without pops, four stored.
    for (int i = 0; i < 5; i++) pq.push_back(8'(8'h50 + i));
    for (int i = 0; i < 4; i++) eq.push_back(8'(8'h50 + i));
    stream(1, 6);
    close(1, mk(1'b0, 4, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0));

    // STOP_ON_ERR: mismatches at bytes 2 and 5, only the first counted.
    for (int i = 0; i < 8; i++) begin
      pq.push_back(8'(8'h70 + i));
      eq.push_back((i == 2 || i == 5) ? 8'hFF : 8'(8'h70 + i));
    end
    stream(1, 2);
    close(1, mk(1'b0, 3, 1, 1'b0, 1'b1, 1'b0, 2, 8'h72, 8'hFF));

    // Pop on empty FIFO.
    eq.push_back(8'h00);
    stream(1, 0);
    close(1, mk(1'b0, 0, 1, 1'b0, 1'b1, 1'b1, 0, 0, 0));

    // Empty-block close straight from IDLE.
    close(1, mk(1'b1, 0, 1, 1'b0, 1'b1, 1'b1, 0, 0, 0));

    // Reset mid-block after 6 pushes.
    for (int i = 0; i < 6; i++) pq.push_back(8'(8'h90 + i));
    stream(0, 0);
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();

    for (int i = 0; i < 4; i++) begin pq.push_back(8'(8'h40 + i)); eq.push_back(8'(8'h40 + i)); end
    stream(0, 1);
    close(0, mk(1'b1, 4, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0));

    for (int i = 0; i < 4; i++) begin pq.push_back(8'(8'h80 + i)); eq.push_back(8'(8'h80 + i)); end
    stream(1, 1);
    close(1, mk(1'b1, 4, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0));

    cyc(); cyc();
    chk("verdicts_outstanding", 0, q0.size(), 0);
    chk("verdicts_outstanding", 1, q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lzrw1_loopback_checker.md
# lzrw1_loopback_checker

Synthesisable, parametrised loopback scoreboard for the LZRW1 compress/decompress pipeline. It records every byte presented to the compressor and checks it, in order, against the byte stream coming out of the decompressor. It reports per-block and cumulative pass/fail status, so loopback checking runs in hardware (FPGA bring-up, long soak runs) and no longer depends on a simulation-only bench. It sits beside the combined compress/decompress core and taps the core's input and output buses without altering them.

## Interface
Parameters:
- DATA_W, 8, width of a stream symbol
- DEPTH, 4096, reference FIFO depth in symbols (power of two, ≥ worst-case core latency in bytes)
- CNT_W, 16, width of byte and mismatch counters
- STOP_ON_ERR, 0, 1 = stop comparing after the first mismatch until the next block starts

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- valid  in  1  a compressor input byte is present this cycle
- CurByte  in  DATA_W  compressor input byte
- out_valid  in  1  a decompressed byte is present this cycle
- decompressed_byte  in  DATA_W  decompressor output byte
- finished_cycle  in  1  one-cycle pulse: the core has finished the current block
- block_done  out  1  one-cycle pulse: block verdict valid
- block_ok  out  1  verdict for the block just closed; held until the next block_done
- pass  out  1  sticky: no error of any kind since reset
- byte_count  out  CNT_W  bytes compared in the current block; saturates
- mismatch_count  out  CNT_W  cumulative mismatches since reset; saturates
- overflow  out  1  sticky: a push was attempted while the FIFO was full
- underflow  out  1  sticky: out_valid arrived while the FIFO was empty
- first_err_index  out  CNT_W  byte_count value at the first mismatch of the current block
- first_err_exp  out  DATA_W  expected byte at the first mismatch
- first_err_act  out  DATA_W  actual byte at the first mismatch

## Operation
- Reset: FIFO empty; FSM in IDLE; pass=1; block_ok=1; every other output 0.
- Push: valid=1 writes CurByte to the FIFO tail. valid=1 with FIFO full and no simultaneous pop: byte dropped, overflow set, pass cleared.
- Pop/compare: out_valid=1 with FIFO non-empty pops the head and compares it against decompressed_byte. out_valid=1 with FIFO empty: nothing is popped, underflow set, pass cleared, block marked bad.
- Simultaneous push and pop: the pop sees occupancy before the push. When full, both proceed and occupancy is unchanged. When empty, the result is underflow and the pushed byte is stored.
- Mismatch:
  - mismatch_count +1, saturating at 2^CNT_W−1.
  - pass cleared; block marked bad.
  - If this is the block's first error, latch first_err_index, first_err_exp and first_err_act.
  - With STOP_ON_ERR=1, later out_valid bytes still pop but are not compared or counted until the block closes.
- FSM states:
  - IDLE: on valid or out_valid → RUN; byte_count cleared; first_err fields cleared.
  - RUN: on finished_cycle → CHECK.
  - CHECK, one cycle: block_ok = (no mismatch, underflow or overflow during the block) AND (FIFO empty). Pulse block_done, then → IDLE.
- finished_cycle in IDLE: an empty-block close. Go straight to CHECK; block_ok=1 if the FIFO is empty.
- finished_cycle in CHECK is ignored.
- Leftover FIFO bytes at CHECK are not flushed. They count as a failure for the closing block and remain as expected data for the next block.
- byte_count counts successful pops in the current block and saturates.

## Timing
- Push is visible in occupancy one cycle after valid.
- Comparison is registered. mismatch_count, byte_count, the first_err fields and the sticky flags update on the edge after out_valid (one-cycle latency).
- CHECK is entered on the edge after finished_cycle. block_done is asserted during CHECK, one cycle after finished_cycle, so any compare from the same cycle as finished_cycle is already included.
- The FIFO pointers wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.
- Reset asserted mid-block returns everything to its reset values immediately, with no block_done.

## Test plan
- Loopback: 16 bytes 0x00–0x0F pushed, then echoed back after 5 cycles, then finished_cycle → block_done one cycle later, block_ok=1, byte_count=16, pass=1, mismatch_count=0.
- Corruption: 8 bytes pushed; the 4th echoed as 0xFF in place of 0x03 → mismatch_count=1, first_err_index=3, first_err_exp=0x03, first_err_act=0xFF, block_ok=0, pass=0.
- Full and boundary, DEPTH=4:
  - 5 pushes without pops → overflow=1, 4 bytes stored.
  - Push plus pop in the same cycle while full → no overflow.
  - Pop on empty → underflow=1.
- Leftover: 10 pushed, 9 popped, finished_cycle → block_ok=0. The next block starts with 1 byte in the FIFO.
- STOP_ON_ERR=1: mismatches at bytes 2 and 5 → mismatch_count=1; all 8 bytes popped; FIFO empty at CHECK.
- Reset mid-block after 6 pushes → all outputs at reset values, no block_done pulse; a following clean block reports block_ok=1.
